// File: rtl/led_show_if.sv
// led_show_if: button, step and playlist-config inputs plus mode/restart outputs of the show sequencer
interface led_show_if;
  logic       btn_next;
  logic       btn_auto;
  logic       step_tick;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_dwell;
  logic [1:0] mode;
  logic       gen_rst;
  logic       auto_on;
  logic [1:0] entry_idx;
  modport master (
    output btn_next, btn_auto, step_tick, cfg_we, cfg_addr, cfg_mode, cfg_dwell,
    input  mode, gen_rst, auto_on, entry_idx
  );
  modport slave (
    input  btn_next, btn_auto, step_tick, cfg_we, cfg_addr, cfg_mode, cfg_dwell,
    output mode, gen_rst, auto_on, entry_idx
  );
endinterface

// File: rtl/led_show_sequencer.sv
// led_show_sequencer: playlist controller choosing the LED generator mode manually or by dwell count
module led_show_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input logic      clk,
  input logic      rst,
  led_show_if.slave bus
);
  localparam logic [1:0] MANUAL = 2'd0;
  localparam logic [1:0] AUTO   = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;
  logic [1:0] raw;
  logic [1:0] press;
  assign raw = {bus.btn_auto, bus.btn_next};
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic             s0, s1, db, db_d;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        s0   <= 1'b0;
        s1   <= 1'b0;
        db   <= 1'b0;
        db_d <= 1'b0;
        cnt  <= '0;
      end else begin
        s0   <= raw[i];
        s1   <= s0;
        db_d <= db;
        if (s1 == db) cnt <= '0;
        else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt <= '0;
          db  <= ~db;
        end else cnt <= cnt + 1'b1;
      end
    // rising edge of the debounced level only; release is silent
    assign press[i] = db & ~db_d;
  end
  logic [1:0] state;
  logic [1:0] pl_mode  [4];
  logic [7:0] pl_dwell [4];
  logic [7:0] step_cnt;
  logic [1:0] idx;
  logic       auto_q;
  logic [1:0] mode_q;
  logic       gen_q;
  logic [7:0] eff;
  logic       done;
  assign eff  = (pl_dwell[idx] == 8'd0) ? 8'd1 : pl_dwell[idx];
  assign done = ({1'b0, step_cnt} + 9'd1) >= {1'b0, eff};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= MANUAL;
      step_cnt <= '0;
      idx      <= '0;
      auto_q   <= 1'b0;
      mode_q   <= '0;
      gen_q    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        pl_mode[k]  <= 2'(k);
        pl_dwell[k] <= 8'd16;
      end
    end else begin
      gen_q <= 1'b0;
      if (bus.cfg_we) begin
        pl_mode[bus.cfg_addr]  <= bus.cfg_mode;
        pl_dwell[bus.cfg_addr] <= bus.cfg_dwell;
      end
      // auto press outranks next press and step_tick; SWITCH swallows all of them
      if (state == SWITCH) begin
        mode_q   <= pl_mode[idx];
        gen_q    <= 1'b1;
        step_cnt <= '0;
        state    <= auto_q ? AUTO : MANUAL;
      end else if (press[1]) begin
        auto_q   <= ~auto_q;
        step_cnt <= '0;
        state    <= auto_q ? MANUAL : AUTO;
      end else if (press[0] || (state == AUTO && bus.step_tick && done)) begin
        idx   <= idx + 2'd1;
        state <= SWITCH;
      end else if (state == AUTO && bus.step_tick) step_cnt <= step_cnt + 8'd1;
    end
  assign bus.mode      = mode_q;
  assign bus.gen_rst   = gen_q;
  assign bus.auto_on   = auto_q;
  assign bus.entry_idx = idx;
endmodule

// File: tb/tb_led_show_sequencer.sv
// tb_led_show_sequencer: directed stimulus against a cycle model of the playlist rules plus literal checkpoints
module tb_led_show_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   gp = 0;
  always #5 clk = ~clk;
  led_show_if bus ();
  led_show_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [1:0] m_mode, m_idx;
  logic       m_gen, m_auto, m_sw;
  int         m_steps;
  logic [1:0] pl_mode [4];
  logic [7:0] pl_dwell [4];
  logic [4:0] hn, ha;
  logic       dn, da, pn, pa, fn, fa;
  int         eff;
  // a button level is accepted once four consecutive synchronised samples disagree with it
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_gen = 0; m_auto = 0; m_idx = 0; m_steps = 0; m_sw = 0;
      for (int i = 0; i < 4; i++) begin pl_mode[i] = 2'(i); pl_dwell[i] = 8'd16; end
      hn = 0; ha = 0; dn = 0; da = 0; pn = 0; pa = 0;
    end else begin
      eff = (pl_dwell[m_idx] == 0) ? 1 : int'(pl_dwell[m_idx]);
      m_gen = 0;
      if (m_sw) begin m_mode = pl_mode[m_idx]; m_gen = 1; m_steps = 0; m_sw = 0; end
      else if (pa) begin m_auto = !m_auto; m_steps = 0; end
      else if (pn) begin m_idx = m_idx + 2'd1; m_sw = 1; end
      else if (m_auto && bus.step_tick) begin
        if (m_steps + 1 >= eff) begin m_idx = m_idx + 2'd1; m_sw = 1; end
        else m_steps = m_steps + 1;
      end
      if (bus.cfg_we) begin pl_mode[bus.cfg_addr] = bus.cfg_mode; pl_dwell[bus.cfg_addr] = bus.cfg_dwell; end
      fn = (hn[4:1] == (dn ? 4'b0000 : 4'b1111));
      fa = (ha[4:1] == (da ? 4'b0000 : 4'b1111));
      pn = fn && !dn;
      pa = fa && !da;
      if (fn) dn = !dn;
      if (fa) da = !da;
      hn = {hn[3:0], bus.btn_next};
      ha = {ha[3:0], bus.btn_auto};
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("model_mode", int'(bus.mode), int'(m_mode));
    chk("model_gen_rst", int'(bus.gen_rst), int'(m_gen));
    chk("model_auto_on", int'(bus.auto_on), int'(m_auto));
    chk("model_entry_idx", int'(bus.entry_idx), int'(m_idx));
    if (bus.gen_rst) gp++;
  end
  task automatic press(input logic bn, input logic ba);
    bus.btn_next = bn; bus.btn_auto = ba;
    repeat (6) @(negedge clk);
    bus.btn_next = 1'b0; bus.btn_auto = 1'b0;
    repeat (10) @(negedge clk);
  endtask
  task automatic tick();
    bus.step_tick = 1'b1;
    @(negedge clk);
    bus.step_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic tick2();
    bus.step_tick = 1'b1;
    repeat (2) @(negedge clk);
    bus.step_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] a, input logic [1:0] m, input logic [7:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_mode = m; bus.cfg_dwell = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask
  initial begin
    bus.btn_next = 0; bus.btn_auto = 0; bus.step_tick = 0;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_mode = 0; bus.cfg_dwell = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_mode", int'(bus.mode), 0);
    chk("reset_idx", int'(bus.entry_idx), 0);
    chk("reset_auto", int'(bus.auto_on), 0);
    chk("reset_gen", int'(bus.gen_rst), 0);
    bus.btn_next = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_next = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_idx", int'(bus.entry_idx), 0);
    chk("glitch_gen_cnt", gp, 0);
    gp = 0;
    bus.btn_next = 1'b1;
    repeat (7) @(negedge clk);
    chk("hold_gen_early", int'(bus.gen_rst), 0);
    @(negedge clk);
    chk("hold_gen_on_time", int'(bus.gen_rst), 1);
    chk("hold_mode", int'(bus.mode), 1);
    chk("hold_idx", int'(bus.entry_idx), 1);
    repeat (2) @(negedge clk);
    bus.btn_next = 1'b0;
    repeat (12) @(negedge clk);
    chk("hold_gen_cnt", gp, 1);
    gp = 0;
    for (int k = 0; k < 4; k++) begin
      press(1'b1, 1'b0);
      chk("wrap_idx", int'(bus.entry_idx), (k + 2) % 4);
      chk("wrap_mode", int'(bus.mode), (k + 2) % 4);
    end
    chk("wrap_gen_cnt", gp, 4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mode", int'(bus.mode), 0);
    chk("async_rst_idx", int'(bus.entry_idx), 0);
    chk("async_rst_gen", int'(bus.gen_rst), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    press(1'b0, 1'b1);
    chk("auto_on", int'(bus.auto_on), 1);
    for (int s = 1; s <= 4; s++) begin
      repeat (16) tick();
      chk("autorun_mode", int'(bus.mode), s % 4);
      chk("autorun_idx", int'(bus.entry_idx), s % 4);
    end
    repeat (32) tick();
    repeat (5) tick();
    chk("live_idx_before", int'(bus.entry_idx), 2);
    wr(2'd2, 2'd2, 8'd4);
    tick();
    chk("live_dwell_idx", int'(bus.entry_idx), 3);
    chk("live_dwell_mode", int'(bus.mode), 3);
    wr(2'd3, 2'd0, 8'd16);
    repeat (4) @(negedge clk);
    chk("live_mode_held", int'(bus.mode), 3);
    press(1'b0, 1'b1);
    chk("manual_auto_off", int'(bus.auto_on), 0);
    chk("manual_idx_held", int'(bus.entry_idx), 3);
    gp = 0;
    press(1'b1, 1'b1);
    chk("prio_auto", int'(bus.auto_on), 1);
    chk("prio_idx", int'(bus.entry_idx), 3);
    chk("prio_gen_cnt", gp, 0);
    press(1'b0, 1'b1);
    wr(2'd0, 2'd0, 8'd3);
    wr(2'd1, 2'd2, 8'd2);
    wr(2'd2, 2'd2, 8'd0);
    press(1'b1, 1'b0);
    chk("next_idx0", int'(bus.entry_idx), 0);
    chk("next_mode0", int'(bus.mode), 0);
    press(1'b0, 1'b1);
    tick();
    tick();
    chk("dwell3_not_yet", int'(bus.entry_idx), 0);
    tick2();
    chk("dwell3_idx", int'(bus.entry_idx), 1);
    chk("dwell3_mode", int'(bus.mode), 2);
    gp = 0;
    tick();
    chk("switch_tick_dropped", int'(bus.entry_idx), 1);
    tick();
    chk("dwell2_idx", int'(bus.entry_idx), 2);
    chk("same_mode_gen_cnt", gp, 1);
    tick();
    chk("dwell0_idx", int'(bus.entry_idx), 3);
    chk("dwell0_mode", int'(bus.mode), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
